load_store_unit: RTL
====================

# load_store_unit

Data-memory access stage that sits directly downstream of the decode stage. It consumes the decoded load/store enables, the effective address, func3, rs2 data and rd, and runs a request/grant/response handshake with the data memory. It aligns and sign-extends load data and returns it with its destination register, and stalls the core while an access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- DR_EN_i  in  1  load request from decode/control
- DWR_EN_i  in  1  store request from decode/control
- address_i  in  ADDR_W  effective address (rs1 + imm) from decode
- func3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- store_data_i  in  DATA_W  rs2 value
- rd_i  in  5  load destination register
- stall_o  out  1  hold PC/decode while high
- load_valid_o  out  1  one-cycle pulse; load_data_o/load_rd_o valid
- load_data_o  out  DATA_W  aligned, extended load result
- load_rd_o  out  5  destination of returned load
- fault_o  out  1  one-cycle pulse: misaligned, illegal func3, or DR and DWR both high
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  DATA_W  lane-replicated store data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_W  read data

## Operation
- FSM states and transitions:
  - IDLE: on (DR_EN_i ^ DWR_EN_i) with a legal, aligned access, latch addr/be/wdata/we/rd/func3/addr[1:0] and go to REQ.
  - REQ: go to WAIT on gnt for a load; go to DONE on gnt for a store.
  - WAIT: on rvalid, register the formatted data and go to DONE.
  - DONE: go to IDLE.
- Alignment rules:
  - W requires addr[1:0]=00.
  - H/HU requires addr[0]=0.
  - B/BU is always aligned.
  - Store func3 must be 000/001/010.
  - A violation, or DR_EN_i and DWR_EN_i both high, gives fault_o=1 for that IDLE cycle. No memory access is made and the FSM stays in IDLE.
- Store formatting:
  - SB: be = 4'b0001<<addr[1:0]; wdata = {4{byte}}.
  - SH: be = 4'b0011<<{addr[1],1'b0}; wdata = {2{half}}.
  - SW: be = 4'b1111.
- Load formatting: select the lane by the latched addr[1:0]. B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- stall_o = (IDLE & accepted request) | REQ | WAIT. stall_o is 0 in DONE and on fault.
- DONE ignores DR_EN_i/DWR_EN_i, because the stalled instruction is still presented that cycle. Requests are accepted only in IDLE.
- mem_rvalid_i and mem_gnt_i outside WAIT/REQ are ignored.

## Timing
- mem_* outputs are registered. mem_req_o is high exactly while in REQ. addr/we/be/wdata stay stable until the gnt cycle.
- Zero-wait load (gnt in the first REQ cycle, rvalid the next cycle):
  - c0 IDLE accept, stall 1
  - c1 REQ, req 1, gnt 1
  - c2 WAIT, rvalid 1
  - c3 DONE, load_valid_o 1, stall 0
- Zero-wait store:
  - c0 accept
  - c1 REQ, gnt
  - c2 DONE, stall 0
- Each cycle of gnt or rvalid delay adds one stall cycle. There is no timeout.
- load_data_o/load_rd_o hold their value until the next load completes. load_valid_o is high only in DONE after a load.
- Reset at any state: next edge gives IDLE, with mem_req_o, mem_we_o, stall_o, load_valid_o and fault_o at 0, and mem_addr_o, mem_be_o, mem_wdata_o, load_data_o and load_rd_o at 0. A pending memory response after reset is ignored.

## Structure
- Shared package lsu_pkg holds:
  - lsu_state_t enum {IDLE, REQ, WAIT, DONE}
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the DATA_W/ADDR_W defaults
- Sub-module lsu_align is combinational. It computes be/wdata for stores, lane extract plus extension for loads, and the misalign/illegal check. The top holds the FSM and registers.

## Test plan
- LW addr 0x100, mem returns 0xDEADBEEF with gnt in c1 and rvalid in c2 -> load_valid_o in c3, load_data_o 0xDEADBEEF, load_rd_o = rd_i, stall_o high c0–c2.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80FF_1234 -> 0xFFFFFF80 and 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SH addr 0x0206, data 0x0000ABCD -> mem_addr 0x204, be 1100, wdata 0xABCDABCD, we 1. gnt held low 3 cycles -> request stable throughout, DONE the cycle after gnt.
- LW addr 0x101, then SH addr 0x3, then DR=DWR=1 -> fault_o pulse each, mem_req_o never asserted, stall_o 0.
- rst_i asserted in WAIT, then rvalid arrives -> IDLE after the edge, no load_valid_o, all outputs 0.
- Back-to-back loads with decode holding during stall -> exactly one memory request per instruction; no re-accept in DONE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, func3
// encodings and default bus widths.
package lsu_pkg;

  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational formatting for the LSU: store byte enables and lane
// replication, load lane extraction with extension, and the legality check.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic [2:0]        i_func3,
  input  logic [1:0]        i_addr_lo,
  input  logic              i_is_store,
  input  logic [DATA_W-1:0] i_store_data,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_fault,
  input  logic [2:0]        i_ld_func3,
  input  logic [1:0]        i_ld_addr_lo,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_load_data
);

  logic [DATA_W-1:0] w_shifted;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // Unsigned variants are loads only; any unlisted func3 is illegal.
  always_comb begin
    o_fault = 1'b0;
    case (i_func3)
      F3_B:    o_fault = 1'b0;
      F3_H:    o_fault = i_addr_lo[0];
      F3_W:    o_fault = |i_addr_lo;
      F3_BU:   o_fault = i_is_store;
      F3_HU:   o_fault = i_is_store | i_addr_lo[0];
      default: o_fault = 1'b1;
    endcase
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_func3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
      end
    endcase
  end

  assign w_shifted = i_rdata >> {i_ld_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_load_data = i_rdata;
    case (i_ld_func3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: request/grant/response FSM toward the data
// memory, with core stall and aligned load write-back.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              DR_EN_i,
  input  logic              DWR_EN_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [2:0]        func3_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [4:0]        rd_i,
  output logic              stall_o,
  output logic              load_valid_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic [4:0]        load_rd_o,
  output logic              fault_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  lsu_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [4:0]        r_rd;
  logic [2:0]        r_func3;
  logic [1:0]        r_addr_lo;
  logic [DATA_W-1:0] r_load_data;
  logic [4:0]        r_load_rd;

  logic              w_accept;
  logic              w_fault;
  logic              w_bad_access;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_data;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_func3      (func3_i),
    .i_addr_lo    (address_i[1:0]),
    .i_is_store   (DWR_EN_i),
    .i_store_data (store_data_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_fault      (w_bad_access),
    .i_ld_func3   (r_func3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem_rdata_i),
    .o_load_data  (w_load_data)
  );

  // Decode enables are only looked at in IDLE; DONE still sees the
  // stalled instruction and must not take it a second time.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      IDLE: begin
        if (DR_EN_i && DWR_EN_i) begin
          w_fault = 1'b1;
        end else if (DR_EN_i || DWR_EN_i) begin
          if (w_bad_access) begin
            w_fault = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = REQ;
          end
        end
      end
      REQ:     if (mem_gnt_i) w_state_next = r_we ? DONE : WAIT;
      WAIT:    if (mem_rvalid_i) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_rd        <= '0;
      r_func3     <= '0;
      r_addr_lo   <= '0;
      r_load_data <= '0;
      r_load_rd   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr    <= {address_i[ADDR_W-1:2], 2'b00};
        r_be      <= w_be;
        r_wdata   <= w_wdata;
        r_we      <= DWR_EN_i;
        r_rd      <= rd_i;
        r_func3   <= func3_i;
        r_addr_lo <= address_i[1:0];
      end
      if (r_state == WAIT && mem_rvalid_i) begin
        r_load_data <= w_load_data;
        r_load_rd   <= r_rd;
      end
    end
  end

  assign stall_o      = w_accept | (r_state == REQ) | (r_state == WAIT);
  assign fault_o      = w_fault;
  assign load_valid_o = (r_state == DONE) & ~r_we;
  assign load_data_o  = r_load_data;
  assign load_rd_o    = r_load_rd;
  assign mem_req_o    = (r_state == REQ);
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_be_o     = r_be;
  assign mem_wdata_o  = r_wdata;

endmodule
